// File: rtl/brazo_pkg.sv
// Shared definitions for the servo arm sequencer: FSM states, frame timing
// defaults and the ROM end-of-sequence marker.
package brazo_pkg;

    typedef enum logic [2:0] {
        REPOSO,
        LEER,
        CARGAR,
        EJECUTAR,
        FIN
    } estado_t;

    // 20 ms frame at 50 MHz
    localparam int CICLOS_TRAMA = 1000000;
    // 1 ms high time for angle 0
    localparam int PULSO_MIN    = 50000;
    // Extra high cycles per angle LSB
    localparam int PASO_ANGULO  = 196;
    // Width of the frame counter and of the PWM compare
    localparam int ANCHO_TRAMA  = 20;
    // Duration value that marks the last step of a sequence
    localparam logic [7:0] MARCA_FIN = 8'hFF;

endpackage

// File: rtl/generador_pwm.sv
// Servo PWM generator: holds the angle for a whole frame (reloaded only at
// condiv==0) and drives pwm high while condiv is below the pulse width.
module generador_pwm #(
    parameter int PULSO_MIN   = brazo_pkg::PULSO_MIN,
    parameter int PASO_ANGULO = brazo_pkg::PASO_ANGULO
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [19:0] condiv,
    input  logic [7:0]  angulo_sig,
    input  logic        ocupado,
    output logic        pwm
);
    import brazo_pkg::*;

    localparam logic [ANCHO_TRAMA-1:0] BASE = ANCHO_TRAMA'(PULSO_MIN);
    localparam logic [ANCHO_TRAMA-1:0] PASO = ANCHO_TRAMA'(PASO_ANGULO);

    logic [7:0]             angulo_act;
    logic [ANCHO_TRAMA-1:0] umbral;

    // Take the next angle only at the start of a frame so a frame never mixes two widths
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            angulo_act <= 8'd0;
        end else if (condiv == 20'd0) begin
            angulo_act <= angulo_sig;
        end
    end

    // Pulse width in cycles, compared unsigned over the full 20-bit range
    always_comb begin
        umbral = BASE + ({12'd0, angulo_act} * PASO);
        pwm    = ocupado && (condiv < umbral);
    end

endmodule

// File: rtl/secuenciador_servo.sv
// Servo sequencer: walks a ROM of {angle, duration} steps, hands each
// duration to the frame-count enable block and drives the servo PWM.
// Optional build macro SECUENCIA_LAZO_EN: at the end of the sequence pulse
// terminado and restart from address 0 instead of stopping.
module secuenciador_servo #(
    parameter int CICLOS_TRAMA = brazo_pkg::CICLOS_TRAMA,
    parameter int ULTIMA_DIR   = 63,
    parameter int PULSO_MIN    = brazo_pkg::PULSO_MIN,
    parameter int PASO_ANGULO  = brazo_pkg::PASO_ANGULO
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iniciar,
    input  logic        habilitador,
    input  logic [15:0] rom_datos,
    output logic [5:0]  rom_dir,
    output logic [19:0] condiv,
    output logic [7:0]  datosROM,
    output logic        pwm,
    output logic        ocupado,
    output logic        terminado
);
    import brazo_pkg::*;

    localparam logic [ANCHO_TRAMA-1:0] ULTIMO_CONDIV = ANCHO_TRAMA'(CICLOS_TRAMA - 1);
    localparam logic [5:0]             DIR_FIN       = 6'(ULTIMA_DIR);

    estado_t    estado;
    logic [7:0] angulo_sig;
    logic       fin_secuencia;

    assign fin_secuencia = (rom_dir == DIR_FIN) || (datosROM == MARCA_FIN);

    // Free-running frame counter, independent of the sequencer state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            condiv <= 20'd0;
        end else if (condiv == ULTIMO_CONDIV) begin
            condiv <= 20'd0;
        end else begin
            condiv <= condiv + 20'd1;
        end
    end

    // Sequencer FSM with registered ocupado/terminado
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            estado     <= REPOSO;
            rom_dir    <= 6'd0;
            datosROM   <= 8'd0;
            angulo_sig <= 8'd0;
            ocupado    <= 1'b0;
            terminado  <= 1'b0;
        end else begin
            terminado <= 1'b0;
            case (estado)
                REPOSO: begin
                    if (iniciar) begin
                        rom_dir <= 6'd0;
                        ocupado <= 1'b1;
                        estado  <= LEER;
                    end
                end
                LEER: begin
                    estado <= CARGAR;
                end
                CARGAR: begin
                    angulo_sig <= rom_datos[15:8];
                    datosROM   <= rom_datos[7:0];
                    estado     <= EJECUTAR;
                end
                EJECUTAR: begin
                    if (habilitador) begin
                        if (fin_secuencia) begin
`ifdef SECUENCIA_LAZO_EN
                            terminado <= 1'b1;
                            rom_dir   <= 6'd0;
                            estado    <= LEER;
`else
                            terminado <= 1'b1;
                            ocupado   <= 1'b0;
                            estado    <= FIN;
`endif
                        end else begin
                            rom_dir <= rom_dir + 6'd1;
                            estado  <= LEER;
                        end
                    end
                end
                FIN: begin
                    estado <= REPOSO;
                end
                default: begin
                    ocupado <= 1'b0;
                    estado  <= REPOSO;
                end
            endcase
        end
    end

    generador_pwm #(
        .PULSO_MIN  (PULSO_MIN),
        .PASO_ANGULO(PASO_ANGULO)
    ) u_pwm (
        .CLK       (CLK),
        .RST       (RST),
        .condiv    (condiv),
        .angulo_sig(angulo_sig),
        .ocupado   (ocupado),
        .pwm       (pwm)
    );

endmodule

// File: tb/tb_secuenciador_servo.sv
// Testbench for secuenciador_servo with a shortened frame so that whole
// frames can be measured. ROM contents are randomized; expected step
// addresses, durations, end step and pulse widths come from the ROM
// contents and the timing rules.
module tb_secuenciador_servo;

    localparam int CT   = 1000;
    localparam int ULT  = 3;
    localparam int PMIN = 50;
    localparam int PASO = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iniciar = 1'b0;
    logic        habilitador = 1'b0;
    logic [15:0] rom_datos;
    logic [5:0]  rom_dir;
    logic [19:0] condiv;
    logic [7:0]  datosROM;
    logic        pwm;
    logic        ocupado;
    logic        terminado;

    logic [15:0] rom [64];
    int unsigned ciclo;
    int          pruebas = 0;
    int          fallos  = 0;

    secuenciador_servo #(
        .CICLOS_TRAMA(CT),
        .ULTIMA_DIR  (ULT),
        .PULSO_MIN   (PMIN),
        .PASO_ANGULO (PASO)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .iniciar    (iniciar),
        .habilitador(habilitador),
        .rom_datos  (rom_datos),
        .rom_dir    (rom_dir),
        .condiv     (condiv),
        .datosROM   (datosROM),
        .pwm        (pwm),
        .ocupado    (ocupado),
        .terminado  (terminado)
    );

    always #5 clk = ~clk;

    // Synchronous ROM with one cycle of read latency
    always @(posedge clk) rom_datos <= rom[rom_dir];

    // Cycles elapsed since reset release
    always @(posedge clk or posedge rst) begin
        if (rst) ciclo <= 0;
        else     ciclo <= ciclo + 1;
    end

    function automatic int condiv_esp();
        return int'(ciclo % CT);
    endfunction

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        pruebas++;
        if (obs !== esp) begin
            fallos++;
            $display("FAIL %s: obtenido %0d, esperado %0d", tag, obs, esp);
        end
    endtask

    task automatic llenar_rom();
        for (int i = 0; i < 64; i++) begin
            rom[i][15:8] = 8'($urandom_range(0, 255));
            rom[i][7:0]  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
        end
    endtask

    // Count pwm high cycles over one full frame starting at condiv==0
    task automatic medir_trama(input int ang);
        int altos;
        altos = 0;
        while (condiv_esp() != 0) @(negedge clk);
        comprobar("condiv_trama", 32'(condiv), 32'd0);
        for (int c = 0; c < CT; c++) begin
            if (pwm) altos++;
            @(negedge clk);
        end
        comprobar("pwm_ancho", 32'(altos), 32'(PMIN + ang * PASO));
    endtask

    // Run one whole sequence from iniciar to its end condition
    task automatic secuencia(input bit medir);
        int fin_k;
        fin_k = ULT;
        for (int i = ULT; i >= 0; i--)
            if (rom[i][7:0] == 8'hFF) fin_k = i;

        iniciar = 1'b1;
        @(negedge clk);
        iniciar = 1'b0;
        comprobar("ocupado_inicio", 32'(ocupado), 32'd1);
        comprobar("dir_inicio", 32'(rom_dir), 32'd0);

        for (int k = 0; k <= fin_k; k++) begin
            // habilitador while reading must be ignored
            habilitador = 1'b1;
            @(negedge clk);
            habilitador = 1'b0;
            comprobar("dir_leer", 32'(rom_dir), 32'(k));
            @(negedge clk);
            comprobar("datosROM", 32'(datosROM), 32'(rom[k][7:0]));
            comprobar("ocupado_paso", 32'(ocupado), 32'd1);
            // iniciar while executing must be ignored
            iniciar = 1'b1;
            @(negedge clk);
            iniciar = 1'b0;
            comprobar("dir_iniciar_ignorado", 32'(rom_dir), 32'(k));
            if (medir) medir_trama(int'(rom[k][15:8]));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            habilitador = 1'b1;
            @(negedge clk);
            habilitador = 1'b0;
            if (k < fin_k) begin
                comprobar("dir_siguiente", 32'(rom_dir), 32'(k + 1));
                comprobar("terminado_paso", 32'(terminado), 32'd0);
            end
        end

`ifdef SECUENCIA_LAZO_EN
        comprobar("terminado_lazo", 32'(terminado), 32'd1);
        comprobar("ocupado_lazo", 32'(ocupado), 32'd1);
        comprobar("dir_lazo", 32'(rom_dir), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`else
        comprobar("terminado_fin", 32'(terminado), 32'd1);
        comprobar("ocupado_fin", 32'(ocupado), 32'd0);
        comprobar("pwm_fin", 32'(pwm), 32'd0);
        @(negedge clk);
        comprobar("terminado_pulso", 32'(terminado), 32'd0);
        habilitador = 1'b1;
        @(negedge clk);
        habilitador = 1'b0;
        comprobar("dir_reposo", 32'(rom_dir), 32'(fin_k));
        comprobar("ocupado_reposo", 32'(ocupado), 32'd0);
        while (condiv_esp() != 2) @(negedge clk);
        comprobar("pwm_reposo", 32'(pwm), 32'd0);
        comprobar("condiv_reposo", 32'(condiv), 32'(condiv_esp()));
`endif
    endtask

    initial begin
        int vistos;
        for (int i = 0; i < 64; i++) rom[i] = 16'd0;
        @(negedge clk);
        @(negedge clk);
        comprobar("rst_condiv", 32'(condiv), 32'd0);
        comprobar("rst_dir", 32'(rom_dir), 32'd0);
        comprobar("rst_datos", 32'(datosROM), 32'd0);
        comprobar("rst_pwm", 32'(pwm), 32'd0);
        comprobar("rst_ocupado", 32'(ocupado), 32'd0);
        comprobar("rst_terminado", 32'(terminado), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        comprobar("condiv_arranque", 32'(condiv), 32'd1);

        // Angle 0 then angle 255 with end marker on step 1
        llenar_rom();
        rom[0] = {8'd0, 8'd2};
        rom[1] = {8'd255, 8'hFF};
        secuencia(1'b1);

        // Random ROM contents
        for (int s = 0; s < 4; s++) begin
            llenar_rom();
            secuencia(1'b1);
        end

        // Reset in the middle of step 1
        rom[0] = {8'd10, 8'd3};
        rom[1] = {8'd20, 8'd4};
        iniciar = 1'b1;
        @(negedge clk);
        iniciar = 1'b0;
        @(negedge clk);
        @(negedge clk);
        habilitador = 1'b1;
        @(negedge clk);
        habilitador = 1'b0;
        @(negedge clk);
        @(negedge clk);
        comprobar("dir_antes_rst", 32'(rom_dir), 32'd1);
        comprobar("ocupado_antes_rst", 32'(ocupado), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        comprobar("abort_condiv", 32'(condiv), 32'd0);
        comprobar("abort_dir", 32'(rom_dir), 32'd0);
        comprobar("abort_datos", 32'(datosROM), 32'd0);
        comprobar("abort_pwm", 32'(pwm), 32'd0);
        comprobar("abort_ocupado", 32'(ocupado), 32'd0);
        comprobar("abort_terminado", 32'(terminado), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        comprobar("condiv_reinicio", 32'(condiv), 32'd1);
        vistos = 0;
        habilitador = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (terminado || ocupado) vistos++;
            @(negedge clk);
        end
        habilitador = 1'b0;
        comprobar("sin_actividad_tras_rst", 32'(vistos), 32'd0);
        comprobar("dir_tras_rst", 32'(rom_dir), 32'd0);

        $display("[TB] %0d tests run, %0d failed", pruebas, fallos);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: obtenido timeout, esperado fin de simulacion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/secuenciador_servo.md
SECUENCIADOR_SERVO -- requirements
Module: secuenciador_servo

Interface
REQ-001 Parameter CICLOS_TRAMA, default 1000000: CLK cycles per 20 ms servo frame at 50 MHz.
REQ-002 Parameter ULTIMA_DIR, default 63: highest valid ROM address.
REQ-003 Parameter PULSO_MIN, default 50000: PWM high cycles (1 ms) for angle 0.
REQ-004 Parameter PASO_ANGULO, default 196: extra high cycles per angle LSB.
REQ-005 CLK  in  1: single clock, rising edge.
REQ-006 RST  in  1: reset, asynchronous, active-high.
REQ-007 iniciar  in  1: one-cycle pulse that starts the sequence.
REQ-008 habilitador  in  1: one-cycle step-done pulse from the frame-count enable block.
REQ-009 rom_datos  in  16: {angulo[15:8], duracion[7:0]}, valid one cycle after rom_dir.
REQ-010 rom_dir  out  6: ROM read address.
REQ-011 condiv  out  20: free-running frame counter, 0..CICLOS_TRAMA-1.
REQ-012 datosROM  out  8: current step duration in frames, fed to the enable block.
REQ-013 pwm  out  1: servo PWM.
REQ-014 ocupado  out  1: high while a sequence runs.
REQ-015 terminado  out  1: one-cycle pulse when the sequence ends.

Function
REQ-016 condiv SHALL increment every cycle and wrap from CICLOS_TRAMA-1 to 0, regardless of FSM state.
REQ-017 FSM states SHALL be REPOSO, LEER, CARGAR, EJECUTAR, FIN.
REQ-018 REPOSO: on iniciar, set rom_dir=0 and go to LEER; otherwise hold.
REQ-019 LEER: present rom_dir for one cycle, then go to CARGAR (1-cycle ROM latency).
REQ-020 CARGAR: latch rom_datos into angulo_sig and datosROM, then go to EJECUTAR.
REQ-021 EJECUTAR: on habilitador, either go to FIN if rom_dir==ULTIMA_DIR or datosROM==8'hFF (end marker), or increment rom_dir and go to LEER.
REQ-022 FIN: pulse terminado for one cycle, then return to REPOSO.
REQ-023 ocupado SHALL be 1 in LEER, CARGAR and EJECUTAR, and 0 otherwise.
REQ-024 habilitador outside EJECUTAR and iniciar outside REPOSO SHALL be ignored.
REQ-025 angulo_act SHALL load from angulo_sig only when condiv==0, so each frame has one consistent pulse width.
REQ-026 pwm SHALL be 1 iff ocupado and condiv < PULSO_MIN + angulo_act*PASO_ANGULO.
REQ-027 The PWM compare SHALL be 20-bit unsigned; 50000+255*196=99980 must fit without overflow.
REQ-028 A step whose end-marker duration is 8'hFF SHALL still drive its angle until its habilitador arrives.

Reset
REQ-029 While RST=1: condiv=0, rom_dir=0, datosROM=0, angulo_sig=angulo_act=0, pwm=0, ocupado=0, terminado=0, FSM=REPOSO.
REQ-030 RST asserted mid-sequence SHALL abort the sequence immediately, with no terminado pulse.
REQ-031 After RST deasserts, condiv SHALL restart from 0 and the block SHALL wait for a new iniciar.

Configuration
REQ-032 With SECUENCIA_LAZO_EN defined, the end condition in EJECUTAR SHALL pulse terminado, set rom_dir=0 and go to LEER, so the sequence repeats with ocupado kept at 1.
REQ-033 Without SECUENCIA_LAZO_EN, the end condition SHALL go to FIN as specified.

Structure
REQ-034 The FSM state enum, CICLOS_TRAMA, PULSO_MIN, PASO_ANGULO and the 8'hFF end marker SHALL live in shared package brazo_pkg.
REQ-035 PWM generation (condiv compare plus angulo_act register) SHALL be sub-module generador_pwm; the FSM and frame counter stay in the top module.

Verification
REQ-036 Scenario: RST pulse mid-EJECUTAR -> next cycle all outputs are 0, state is REPOSO, and no terminado pulse occurs.
REQ-037 Scenario: iniciar with ROM[0]={8'd0,8'd2} -> rom_dir=0; datosROM=2 two cycles later; pwm high 50000 cycles per frame from the next condiv==0.
REQ-038 Scenario: ROM[0] angle 255 -> pwm high exactly 99980 cycles per 1000000-cycle frame.
REQ-039 Scenario: ROM[1].duracion=8'hFF, habilitador in step 1 -> terminado pulses one cycle, ocupado falls, pwm stays 0.
REQ-040 Scenario: habilitador in REPOSO, and iniciar during EJECUTAR -> no rom_dir change, no state change.
REQ-041 Scenario: SECUENCIA_LAZO_EN, ULTIMA_DIR=1 -> after step 1, terminado pulses, rom_dir returns to 0, and ocupado stays 1.
